fifo_wm_v4: RTL and testbench
=============================

Name: fifo_wm_v4

Overview:
Next-generation parametrised FIFO for IOMMU queues (CQ/FQ staging, PTW request buffering); a drop-in superset of the existing v3 FIFO.
- Adds: programmable almost-full/almost-empty watermarks, unambiguous full-range usage count, non-power-of-2 depth wrap, sticky overflow/underflow error flags with explicit clear.
- Sits between a producer and consumer using push/pop handshakes; flags feed back-pressure and IOMMU error reporting.

Parameters:
FALL_THROUGH, 1'b0, 1 = data_i visible on data_o in the same cycle when empty
DATA_WIDTH, 32, payload width in bits
DEPTH, 8, number of entries, 1..1024, any integer (power of 2 not required)
AF_TH, DEPTH-1, almost_full_o asserts when usage >= AF_TH; legal 1..DEPTH
AE_TH, 1, almost_empty_o asserts when usage <= AE_TH; legal 0..DEPTH-1
ADDR_W, (DEPTH>1)?$clog2(DEPTH):1, derived, not overridable

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
flush_i  in  1  synchronous clear of contents
clr_err_i  in  1  synchronous clear of sticky error flags
push_i  in  1  producer request to write data_i
data_i  in  DATA_WIDTH  write payload
pop_i  in  1  consumer request to remove head
data_o  out  DATA_WIDTH  head entry
full_o  out  1  usage == DEPTH
empty_o  out  1  no data available
almost_full_o  out  1  usage >= AF_TH
almost_empty_o  out  1  usage <= AE_TH
usage_o  out  ADDR_W+1  entries stored, 0..DEPTH
overflow_o  out  1  sticky: push dropped
underflow_o  out  1  sticky: pop ignored

Behaviour:
Reset and clocking:
- Reset is asynchronous, active-low, on rst_ni; clock is clk_i.
- Reset values: rd_ptr = wr_ptr = 0, usage_o = 0, empty_o = 1, full_o = 0, almost_empty_o = 1, almost_full_o = (AF_TH == 0 ? 1 : 0), overflow_o = underflow_o = 0.
- data_o is 0 after reset. Storage array is not reset.
- Reset mid-operation discards all entries immediately.

Handshake:
- pop_acc = pop_i && (!empty_o).
- push_acc = push_i && (!full_o || pop_acc).
- Push while full with a simultaneous accepted pop is accepted; usage is unchanged.
- Non-fall-through: pop and push in the same cycle on an empty FIFO accept the push only. The pop is ignored and sets underflow_o.

Fall-through (FALL_THROUGH = 1) when usage == 0 and push_i:
- data_o = data_i and empty_o = 0, combinationally.
- If pop_i is also high, the word bypasses storage: usage stays 0 and pointers do not move.

Non-fall-through:
- A written word appears on data_o the cycle after the push; latency is 1.
- empty_o = (usage == 0) strictly registered-derived.

Pointers and usage:
- Pointers increment modulo DEPTH: at DEPTH-1 they wrap to 0, with no power-of-2 aliasing.
- usage_next = usage + push_acc - pop_acc, never outside 0..DEPTH.
- Flags are derived combinationally from the registered usage, except the fall-through empty_o override.

Flush:
- flush_i has priority over push and pop in the same cycle.
- Next cycle: usage = 0, pointers = 0, empty_o = 1.
- Flush does NOT clear overflow_o or underflow_o.

Errors:
- overflow_o sets the cycle after push_i && !push_acc.
- underflow_o sets the cycle after pop_i && !pop_acc. The fall-through bypass case is not an underflow.
- Error flags clear only via clr_err_i. If clr_err_i coincides with a new error event, set wins.
- A dropped push never corrupts storage or pointers.

DEPTH == 1: full_o = !empty_o, ADDR_W = 1, and the single pointer is held at 0.

Test Plan:
- DEPTH=5, non-FT: push 0x11..0x55 on 5 consecutive cycles. Then full_o = 1, usage_o = 5, almost_full_o = 1 from usage 4. Pop 5 times → data_o sequence 0x11,0x22,0x33,0x44,0x55, then empty_o = 1.
- DEPTH=5 wrap: push 3, pop 3, push 5 values. Then rd_ptr/wr_ptr wrap 4→0 and order is preserved; usage_o = 5 with no overflow_o.
- Full plus simultaneous push/pop: usage stays 5, the new word is read last, overflow_o = 0. Push alone while full → word dropped, overflow_o = 1 next cycle, contents unchanged.
- FT=1, empty, push 0xAB with pop in the same cycle → data_o = 0xAB that cycle, usage_o stays 0, underflow_o = 0. Non-FT same stimulus → data written, usage 1, underflow_o = 1.
- Flush with push asserted and usage=3 → next cycle usage_o = 0, empty_o = 1, error flags retained. clr_err_i → flags 0 next cycle.
- Async reset asserted mid-stream (usage 4) between clock edges → outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fifo_wm_v4.sv
// Parametrised FIFO with programmable watermarks, full-range usage count,
// non-power-of-2 wrap and sticky overflow/underflow flags.
module fifo_wm_v4 #(
  parameter logic FALL_THROUGH = 1'b0,
  parameter int   DATA_WIDTH   = 32,
  parameter int   DEPTH        = 8,
  parameter int   AF_TH        = DEPTH - 1,
  parameter int   AE_TH        = 1,
  localparam int  ADDR_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  clr_err_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o,
  output logic [ADDR_W:0]       usage_o,
  output logic                  overflow_o,
  output logic                  underflow_o
);

  localparam logic [ADDR_W:0]   DEPTH_U  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   AF_U     = (ADDR_W+1)'(AF_TH);
  localparam logic [ADDR_W:0]   AE_U     = (ADDR_W+1)'(AE_TH);
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0]     rd_ptr_q, wr_ptr_q;
  logic [ADDR_W:0]       usage_q, usage_d;
  logic                  ovf_q, udf_q;
  logic                  stored_empty, ft_show, bypass;
  logic                  pop_acc, push_acc, wr_en, rd_en;

  // Explicit wrap at DEPTH-1; with DEPTH == 1 the pointer never leaves 0.
  function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + ADDR_W'(1);
  endfunction

  assign stored_empty = (usage_q == '0);
  assign ft_show      = FALL_THROUGH && stored_empty && push_i;
  assign bypass       = ft_show && pop_i;

  assign empty_o        = stored_empty && !ft_show;
  assign full_o         = (usage_q == DEPTH_U);
  assign almost_full_o  = (usage_q >= AF_U);
  assign almost_empty_o = (usage_q <= AE_U);
  assign usage_o        = usage_q;
  assign overflow_o     = ovf_q;
  assign underflow_o    = udf_q;

  assign pop_acc  = pop_i && !empty_o;
  assign push_acc = push_i && (!full_o || pop_acc);
  // A bypassed word is handed straight through and never touches storage.
  assign wr_en    = push_acc && !bypass;
  assign rd_en    = pop_acc && !bypass;

  assign data_o = ft_show      ? data_i :
                  stored_empty ? '0     : mem_q[rd_ptr_q];

  always_comb begin
    usage_d = usage_q;
    case ({wr_en, rd_en})
      2'b10:   usage_d = usage_q + (ADDR_W+1)'(1);
      2'b01:   usage_d = usage_q - (ADDR_W+1)'(1);
      default: usage_d = usage_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      usage_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      usage_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (rd_en) rd_ptr_q <= ptr_inc(rd_ptr_q);
      usage_q <= usage_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  // Set beats clear when both happen in the same cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (push_i && !push_acc) ovf_q <= 1'b1;
      else if (clr_err_i)      ovf_q <= 1'b0;
      if (pop_i && !pop_acc)   udf_q <= 1'b1;
      else if (clr_err_i)      udf_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_wm_v4.sv
// Bench for fifo_wm_v4: a non-fall-through and a fall-through instance (DEPTH=5)
// share stimulus and are checked every cycle against a queue model.
module tb_fifo_wm_v4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic push = 1'b0, pop = 1'b0, flush = 1'b0, clr = 1'b0;
  logic [7:0] din = '0;

  logic [1:0][7:0] dat_w;
  logic [1:0][3:0] use_w;
  logic [1:0]      full_w, empty_w, af_w, ae_w, ovf_w, udf_w;

  int n_chk = 0, n_fail = 0;
  bit chk_en = 1'b0;

  logic [7:0] q0[$], q1[$];
  bit ovf_m[2], udf_m[2];

  always #5 clk = ~clk;

  fifo_wm_v4 #(.FALL_THROUGH(1'b0), .DATA_WIDTH(8), .DEPTH(5)) u_nft (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .clr_err_i(clr),
    .push_i(push), .data_i(din), .pop_i(pop), .data_o(dat_w[0]),
    .full_o(full_w[0]), .empty_o(empty_w[0]), .almost_full_o(af_w[0]),
    .almost_empty_o(ae_w[0]), .usage_o(use_w[0]), .overflow_o(ovf_w[0]),
    .underflow_o(udf_w[0]));

  fifo_wm_v4 #(.FALL_THROUGH(1'b1), .DATA_WIDTH(8), .DEPTH(5)) u_ft (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .clr_err_i(clr),
    .push_i(push), .data_i(din), .pop_i(pop), .data_o(dat_w[1]),
    .full_o(full_w[1]), .empty_o(empty_w[1]), .almost_full_o(af_w[1]),
    .almost_empty_o(ae_w[1]), .usage_o(use_w[1]), .overflow_o(ovf_w[1]),
    .underflow_o(udf_w[1]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected outputs follow from the queue contents; then the queue advances.
  task automatic step_model(input int i);
    logic [7:0] q[$];
    int cnt;
    bit ft, disp, byp, e_empty, e_full, pop_ok, push_ok;
    logic [7:0] e_data;
    if (i == 0) q = q0; else q = q1;
    ft      = (i == 1);
    cnt     = q.size();
    disp    = ft && cnt == 0 && push;
    byp     = disp && pop;
    e_empty = (cnt == 0) && !disp;
    e_full  = (cnt == 5);
    e_data  = disp ? din : (cnt == 0 ? 8'h00 : q[0]);
    chk($sformatf("data[%0d]", i),  32'(dat_w[i]),   32'(e_data));
    chk($sformatf("empty[%0d]", i), 32'(empty_w[i]), 32'(e_empty));
    chk($sformatf("full[%0d]", i),  32'(full_w[i]),  32'(e_full));
    chk($sformatf("af[%0d]", i),    32'(af_w[i]),    32'(cnt >= 4));
    chk($sformatf("ae[%0d]", i),    32'(ae_w[i]),    32'(cnt <= 1));
    chk($sformatf("usage[%0d]", i), 32'(use_w[i]),   32'(cnt));
    chk($sformatf("ovf[%0d]", i),   32'(ovf_w[i]),   32'(ovf_m[i]));
    chk($sformatf("udf[%0d]", i),   32'(udf_w[i]),   32'(udf_m[i]));
    pop_ok  = pop && !e_empty;
    push_ok = push && (!e_full || pop_ok);
    if (flush) q.delete();
    else if (!byp) begin
      if (pop_ok)  void'(q.pop_front());
      if (push_ok) q.push_back(din);
    end
    if (push && !push_ok) ovf_m[i] = 1'b1; else if (clr) ovf_m[i] = 1'b0;
    if (pop && !pop_ok)   udf_m[i] = 1'b1; else if (clr) udf_m[i] = 1'b0;
    if (i == 0) q0 = q; else q1 = q;
  endtask

  always @(negedge clk) begin
    #4;
    if (chk_en) begin
      step_model(0);
      step_model(1);
    end
  end

  task automatic cyc(input logic p, input logic [7:0] d, input logic o,
                     input logic f = 1'b0, input logic c = 1'b0);
    @(negedge clk);
    push = p; din = d; pop = o; flush = f; clr = c;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1; chk_en = 1'b1;
    #4;
    chk("rst_usage", 32'(use_w[0]), 0);
    chk("rst_empty", 32'(empty_w[0]), 1);
    chk("rst_ae", 32'(ae_w[0]), 1);
    chk("rst_data", 32'(dat_w[0]), 0);

    // fill 0x11..0x55, watermark from usage 4
    for (int k = 1; k <= 5; k++) begin
      cyc(1'b1, 8'(k * 8'h11), 1'b0);
      if (k == 5) begin #4; chk("af_at4", 32'(af_w[0]), 1); chk("use_at4", 32'(use_w[0]), 4); end
    end
    cyc(1'b0, 8'h00, 1'b0);
    #4;
    chk("full5", 32'(full_w[0]), 1);
    chk("use5", 32'(use_w[0]), 5);
    for (int k = 1; k <= 5; k++) begin
      cyc(1'b0, 8'h00, 1'b1);
      #4; chk($sformatf("pop_data%0d", k), 32'(dat_w[0]), 32'(k * 8'h11));
    end
    cyc(1'b0, 8'h00, 1'b0);
    #4; chk("empty_after", 32'(empty_w[0]), 1);

    // pointer wrap
    for (int k = 0; k < 3; k++) cyc(1'b1, 8'(8'hA1 + k), 1'b0);
    for (int k = 0; k < 3; k++) cyc(1'b0, 8'h00, 1'b1);
    for (int k = 0; k < 5; k++) cyc(1'b1, 8'(8'hB1 + k), 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    #4;
    chk("wrap_use", 32'(use_w[0]), 5);
    chk("wrap_head", 32'(dat_w[0]), 32'h B1);
    chk("wrap_ovf", 32'(ovf_w[0]), 0);

    // full: push+pop accepted, push alone dropped
    cyc(1'b1, 8'hC6, 1'b1);
    cyc(1'b1, 8'hDD, 1'b0);
    #4; chk("fullpp_use", 32'(use_w[0]), 5); chk("fullpp_ovf", 32'(ovf_w[0]), 0);
    for (int k = 0; k < 5; k++) begin
      cyc(1'b0, 8'h00, 1'b1);
      if (k == 0) begin #4; chk("drop_ovf", 32'(ovf_w[0]), 1); chk("drop_head", 32'(dat_w[0]), 32'hB2); end
      if (k == 4) begin #4; chk("last_c6", 32'(dat_w[0]), 32'hC6); end
    end

    // push+pop on empty: FT bypass vs non-FT underflow
    cyc(1'b1, 8'hAB, 1'b1);
    #4;
    chk("ft_byp_data", 32'(dat_w[1]), 32'hAB);
    chk("ft_byp_empty", 32'(empty_w[1]), 0);
    chk("nft_data0", 32'(dat_w[0]), 0);
    cyc(1'b0, 8'h00, 1'b0);
    #4;
    chk("ft_byp_use", 32'(use_w[1]), 0);
    chk("ft_byp_udf", 32'(udf_w[1]), 0);
    chk("nft_use1", 32'(use_w[0]), 1);
    chk("nft_udf", 32'(udf_w[0]), 1);
    chk("nft_ab", 32'(dat_w[0]), 32'hAB);

    // flush keeps error flags, clr_err clears, set beats clear
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) cyc(1'b1, 8'(8'h31 + k), 1'b0);
    cyc(1'b1, 8'h99, 1'b0, 1'b1);
    #4; chk("pre_flush_use", 32'(use_w[0]), 3);
    cyc(1'b0, 8'h00, 1'b0);
    #4;
    chk("flush_use", 32'(use_w[0]), 0);
    chk("flush_empty", 32'(empty_w[1]), 1);
    chk("flush_keep_ovf", 32'(ovf_w[0]), 1);
    chk("flush_keep_udf", 32'(udf_w[0]), 1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 1'b0);
    #4; chk("clr_ovf", 32'(ovf_w[0]), 0); chk("clr_udf", 32'(udf_w[0]), 0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 1'b0);
    #4; chk("set_wins0", 32'(udf_w[0]), 1); chk("set_wins1", 32'(udf_w[1]), 1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // async reset mid-stream at usage 4
    for (int k = 0; k < 4; k++) cyc(1'b1, 8'(8'h41 + k), 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    #2; chk_en = 1'b0;
    chk("pre_rst_use", 32'(use_w[0]), 4);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("arst_use%0d", i), 32'(use_w[i]), 0);
      chk($sformatf("arst_empty%0d", i), 32'(empty_w[i]), 1);
      chk($sformatf("arst_af%0d", i), 32'(af_w[i]), 0);
      chk($sformatf("arst_data%0d", i), 32'(dat_w[i]), 0);
    end
    q0.delete(); q1.delete();
    ovf_m = '{0, 0}; udf_m = '{0, 0};
    @(negedge clk);
    rst_n = 1'b1; chk_en = 1'b1;
    cyc(1'b1, 8'h5A, 1'b0);
    cyc(1'b0, 8'h00, 1'b1);
    #4; chk("post_rst_data", 32'(dat_w[0]), 32'h5A);
    cyc(1'b0, 8'h00, 1'b0);
    @(negedge clk);
    #6; chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
